// File: rtl/pwm_compare_if.sv
// rtl/pwm_compare_if.sv - counter/duty/PWM signal bundle between the counter stage and pwm_compare
interface pwm_compare_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] count;
  logic             ovf;
  logic [WIDTH-1:0] duty_in;
  logic             duty_wr;
  logic             duty_pend;
  logic             pwm;
  logic             pwm_n;

  modport master (
    output count, ovf, duty_in, duty_wr,
    input  duty_pend, pwm, pwm_n
  );

  modport slave (
    input  count, ovf, duty_in, duty_wr,
    output duty_pend, pwm, pwm_n
  );
endinterface

// File: rtl/pwm_compare.sv
// rtl/pwm_compare.sv - double-buffered duty PWM compare; optional dead-band pair under PWM_DEADTIME_EN
module pwm_compare #(
  parameter int WIDTH    = 8,
  parameter int DEADTIME = 4
) (
  input logic         clk,
  input logic         rst,
  pwm_compare_if.slave bus
);

  if (DEADTIME < 1 || DEADTIME > 15) begin : g_bad_deadtime
    $error("pwm_compare: DEADTIME must be in 1..15");
  end

  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic             pend_q, pend_d;
  logic             r_q, r_d;

  // Apply the pending shadow before capturing a simultaneous write, so the
  // new write stays pending for the following period.
  always_comb begin
    duty_sh_d  = duty_sh_q;
    duty_act_d = duty_act_q;
    pend_d     = pend_q;
    if (bus.ovf && pend_q) begin
      duty_act_d = duty_sh_q;
      pend_d     = 1'b0;
    end
    if (bus.duty_wr) begin
      duty_sh_d = bus.duty_in;
      pend_d    = 1'b1;
    end
    r_d = (bus.count < duty_act_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pend_q     <= 1'b0;
      r_q        <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pend_q     <= pend_d;
      r_q        <= r_d;
    end
  end

  assign bus.duty_pend = pend_q;

`ifdef PWM_DEADTIME_EN
  localparam logic [3:0] DeadCycles = 4'(DEADTIME);

  // stab_q = cycles r has already held its level before the current one.
  logic [3:0] stab_q, stab_d;

  always_comb begin
    stab_d = stab_q;
    if (r_d != r_q) begin
      stab_d = 4'd0;
    end else if (stab_q != 4'hF) begin
      stab_d = stab_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= 4'd0;
    end else begin
      stab_q <= stab_d;
    end
  end

  assign bus.pwm   =  r_q && (stab_q >= DeadCycles);
  assign bus.pwm_n = !r_q && (stab_q >= DeadCycles);
`else
  assign bus.pwm   =  r_q;
  assign bus.pwm_n = ~r_q;
`endif

endmodule
